shift_unit: RTL and testbench

SHIFT_UNIT -- requirements
Module: shift_unit

---
 rtl/shift_unit.sv | 141 ++++++++++++++
 tb/tb_shift_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/shift_unit.sv
// shift_unit -- multi-cycle shifter / rotator with valid/ready handshakes.
//
// A request (in_data, in_shift, in_mode) is captured in IDLE. The unit then
// shifts the accumulator by at most STEP bits per clock in BUSY until the
// remaining distance is exhausted, and presents the result in DONE until
// the consumer takes it.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (ready only in IDLE)
//   in_data             operand, WIDTH bits
//   in_shift            shift distance 0..WIDTH-1
//   in_mode             000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others reserved
//   out_valid/out_ready result handshake (valid only in DONE)
//   out_data            result (the accumulator)
//   out_err             result came from a reserved mode
//   busy                unit is not in IDLE
module shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shift,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [2:0] M_SLL = 3'd0;
  localparam logic [2:0] M_SRL = 3'd1;
  localparam logic [2:0] M_SRA = 3'd2;
  localparam logic [2:0] M_ROL = 3'd3;
  localparam logic [2:0] M_ROR = 3'd4;

  // One bit wider than rem so STEP == WIDTH is representable.
  localparam logic [SHW:0] STEP_W  = (SHW+1)'(STEP);
  localparam logic [SHW:0] WIDTH_W = (SHW+1)'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   rem;
  logic [2:0]       mode;

  logic [SHW-1:0]   d;
  logic [SHW:0]     d_inv;
  logic [WIDTH-1:0] acc_nxt;
  logic             accept;
  logic             reserved;

  // Ready is gated by rst_n so it reads 0 for the whole reset window.
  assign in_ready = (state == IDLE) && rst_n;
  assign accept   = in_valid && in_ready;
  assign reserved = (in_mode > M_ROR);
  assign out_data = acc;

  // Per-clock distance d = min(STEP, rem). When STEP == WIDTH the first
  // branch is never taken because rem < WIDTH.
  always_comb begin
    d = rem;
    if ({1'b0, rem} > STEP_W) d = STEP_W[SHW-1:0];
    d_inv = WIDTH_W - {1'b0, d};
  end

  // SRA keeps the sign bit in the MSB of acc on every step, so repeated
  // arithmetic shifts keep filling with the original operand MSB.
  always_comb begin
    acc_nxt = acc;
    case (mode)
      M_SLL:   acc_nxt = acc << d;
      M_SRL:   acc_nxt = acc >> d;
      M_SRA:   acc_nxt = WIDTH'($signed(acc) >>> d);
      M_ROL:   acc_nxt = (acc << d) | (acc >> d_inv);
      M_ROR:   acc_nxt = (acc >> d) | (acc << d_inv);
      default: acc_nxt = acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      rem       <= '0;
      mode      <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc  <= in_data;
            rem  <= in_shift;
            mode <= in_mode;
            busy <= 1'b1;
            // Nothing to shift: result is the operand itself.
            if (in_shift == '0 || reserved) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_err   <= reserved;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc <= acc_nxt;
          rem <= rem - d;
          if (rem == d) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_err   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit -- self-checking bench for shift_unit (WIDTH=32, STEP=4).
// Expected results come from a word-level reference model built on 64-bit
// concatenations; latency is expected as 1 + ceil(shift/STEP).
module tb_shift_unit;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;
  localparam int SHW   = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shift;
  logic [2:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic             busy;

  int checks = 0;
  int errors = 0;

  shift_unit #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shift(in_shift), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: whole-word shift by the full distance.
  function automatic logic [31:0] model(input logic [31:0] d, input int s,
                                        input logic [2:0] m);
    logic [63:0] w;
    case (m)
      3'd0:    begin w = {32'b0, d} << s;        return w[31:0];  end
      3'd1:    begin w = {32'b0, d} >> s;        return w[31:0];  end
      3'd2:    begin w = {{32{d[31]}}, d} >> s;  return w[31:0];  end
      3'd3:    begin w = {d, d} << s;            return w[63:32]; end
      3'd4:    begin w = {d, d} >> s;            return w[31:0];  end
      default: return d;
    endcase
  endfunction

  function automatic int exp_lat(input int s, input logic [2:0] m);
    if (m > 3'd4 || s == 0) return 1;
    return 1 + (s + STEP - 1) / STEP;
  endfunction

  // Issue one request from IDLE and wait (bounded) for out_valid. Returns at
  // the negedge where out_valid is first seen; the result is not yet taken.
  task automatic run_op(input logic [31:0] d, input int s, input logic [2:0] m,
                        input bit pulse, output logic [31:0] res,
                        output logic err, output int lat, output bit to);
    @(negedge clk);
    in_data = d; in_shift = SHW'(s); in_mode = m; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 1; to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin to = 1'b0; break; end
      if (pulse) begin
        in_valid = 1'b1; in_data = $urandom; in_shift = SHW'($urandom);
        in_mode = 3'($urandom);
      end
      @(posedge clk); #1 in_valid = 1'b0;
      lat++;
    end
    in_valid = 1'b0;
    res = out_data; err = out_err;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0; in_mode = '0;
    out_ready = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (busy !== 1'b0 || out_err !== 1'b0) begin errors++; $display("FAIL reset_busy_err got %b%b want 00", busy, out_err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] vd [7] = '{32'd456, 32'h80000000, 32'h80000000, 32'h1,
                            32'h80000000, 32'hDEADBEEF, 32'h12345678};
    int          vs [7] = '{7, 31, 31, 1, 4, 0, 9};
    logic [2:0]  vm [7] = '{3'd0, 3'd2, 3'd1, 3'd4, 3'd3, 3'd0, 3'd7};
    logic [31:0] ve [7] = '{32'd58368, 32'hFFFFFFFF, 32'h1, 32'h80000000,
                            32'h8, 32'hDEADBEEF, 32'h12345678};
    logic        vr [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int          vl [7] = '{3, 9, 9, 2, 2, 1, 1};
    logic [31:0] res; logic err; int lat; bit to;
    for (int i = 0; i < 7; i++) begin
      run_op(vd[i], vs[i], vm[i], 1'b0, res, err, lat, to);
      checks++; if (to) begin errors++; $display("FAIL dir%0d_timeout no out_valid within bound", i); end
      checks++; if (res !== ve[i]) begin errors++; $display("FAIL dir%0d_data got %h want %h", i, res, ve[i]); end
      checks++; if (err !== vr[i]) begin errors++; $display("FAIL dir%0d_err got %b want %b", i, err, vr[i]); end
      checks++; if (lat !== vl[i]) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, vl[i]); end
      release_out();
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] d, res, exp; logic err; int lat; bit to;
    d = $urandom; exp = model(d, 29, 3'd4);
    run_op(d, 29, 3'd4, 1'b1, res, err, lat, to);
    checks++; if (to || res !== exp) begin errors++; $display("FAIL busy_ignore_data got %h want %h", res, exp); end
    checks++; if (lat !== exp_lat(29, 3'd4)) begin errors++; $display("FAIL busy_ignore_latency got %0d want %0d", lat, exp_lat(29, 3'd4)); end
    release_out();
  endtask

  task automatic test_backpressure();
    logic [31:0] res; logic err; int lat; bit to;
    run_op(32'hA5A5_0F0F, 13, 3'd1, 1'b0, res, err, lat, to);
    checks++; if (to || res !== model(32'hA5A5_0F0F, 13, 3'd1)) begin errors++; $display("FAIL bp_data got %h want %h", res, model(32'hA5A5_0F0F, 13, 3'd1)); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== res || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got v=%b d=%h r=%b want v=1 d=%h r=0", i, out_valid, out_data, in_ready, res);
      end
    end
    release_out();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; logic err; int lat; bit to; bit seen;
    @(negedge clk);
    in_data = 32'hFFFF_0000; in_shift = 5'd31; in_mode = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_async got v=%b d=%h b=%b r=%b want all 0", out_valid, out_data, busy, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_ghost got out_valid=1 want 0"); end
    run_op(32'h0F, 4, 3'd0, 1'b0, res, err, lat, to);
    checks++; if (to || res !== 32'hF0) begin errors++; $display("FAIL midreset_next got %h want 000000f0", res); end
    release_out();
  endtask

  task automatic test_random();
    logic [31:0] d, res, exp; logic [2:0] m; int s; logic err; int lat; bit to;
    int bad = 0;
    for (int i = 0; i < 40; i++) begin
      d = $urandom; s = $urandom_range(0, 31); m = 3'($urandom_range(0, 7));
      exp = model(d, s, m);
      run_op(d, s, m, 1'b0, res, err, lat, to);
      checks++;
      if (to || res !== exp || err !== (m > 3'd4) || lat !== exp_lat(s, m)) begin
        errors++;
        $display("FAIL rand%0d d=%h s=%0d m=%0d got %h/%b/%0d want %h/%b/%0d",
                 i, d, s, m, res, err, lat, exp, (m > 3'd4), exp_lat(s, m));
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
